// File: rtl/alu_issue.sv
// ALU issue stage: 2-entry in-order buffer (main + skid) in front of the ALU,
// with registered s_ready, per-entry opcode flags and saturating retire counters.
module alu_issue #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_in1,
    input  logic [31:0]      s_in2,
    input  logic [2:0]       s_opcode,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_in1,
    output logic [31:0]      m_in2,
    output logic [2:0]       m_opcode,
    output logic             m_illegal,
    output logic             m_shovf,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] illegal_cnt,
    input  logic             cnt_clr
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [2:0]  opcode;
        logic        illegal;
        logic        shovf;
    } entry_t;

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_s_ready;
    entry_t           r_main;
    entry_t           r_skid;
    entry_t           w_new;
    logic             w_accept;
    logic             w_retire;
    logic             w_main_ld;
    logic             w_main_from_skid;
    logic             w_skid_ld;
    logic [CNT_W-1:0] r_issue_cnt;
    logic [CNT_W-1:0] r_illegal_cnt;

    assign w_accept = s_valid && r_s_ready;
    assign w_retire = m_valid && m_ready;

    // Flags are resolved once at accept so the ALU side sees them with the entry.
    always_comb begin
        w_new.in1     = s_in1;
        w_new.in2     = s_in2;
        w_new.opcode  = s_opcode;
        w_new.illegal = (s_opcode == 3'b010) || (s_opcode == 3'b011);
        w_new.shovf   = (s_opcode == 3'b111) && (s_in2 > 32'd31);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_main_ld        = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_ld        = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_main_ld   = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_retire) begin
                    w_state_nxt = ST_TWO;
                    w_skid_ld   = 1'b1;
                end else if (w_accept && w_retire) begin
                    w_main_ld   = 1'b1;
                end else if (w_retire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_retire) begin
                    w_state_nxt      = ST_ONE;
                    w_main_ld        = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // s_ready is a flop of the next occupancy, so m_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_ready <= 1'b0;
        end else begin
            r_s_ready <= (w_state_nxt != ST_TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_main_ld) begin
                r_main <= w_main_from_skid ? r_skid : w_new;
            end
            if (w_skid_ld) begin
                r_skid <= w_new;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_cnt   <= '0;
            r_illegal_cnt <= '0;
        end else if (cnt_clr) begin
            r_issue_cnt   <= '0;
            r_illegal_cnt <= '0;
        end else if (w_retire) begin
            if (r_issue_cnt != {CNT_W{1'b1}}) begin
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            end
            if (r_main.illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
                r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
            end
        end
    end

    assign s_ready     = r_s_ready;
    assign m_valid     = (r_state != ST_EMPTY);
    // Fields read as zero whenever nothing is presented.
    assign m_in1       = m_valid ? r_main.in1     : 32'd0;
    assign m_in2       = m_valid ? r_main.in2     : 32'd0;
    assign m_opcode    = m_valid ? r_main.opcode  : 3'd0;
    assign m_illegal   = m_valid && r_main.illegal;
    assign m_shovf     = m_valid && r_main.shovf;
    assign issue_cnt   = r_issue_cnt;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: queue-based reference model checked every negedge on a
// default-width and a CNT_W=4 instance, plus directed literal checks.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        m_ready = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [31:0] s_in1 = '0;
    logic [31:0] s_in2 = '0;
    logic [2:0]  s_opcode = '0;

    logic        s_ready, m_valid, m_illegal, m_shovf;
    logic [31:0] m_in1, m_in2;
    logic [2:0]  m_opcode;
    logic [15:0] issue_cnt, illegal_cnt;

    logic        s_ready4, m_valid4, m_illegal4, m_shovf4;
    logic [31:0] m_in14, m_in24;
    logic [2:0]  m_opcode4;
    logic [3:0]  issue_cnt4, illegal_cnt4;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_issue u_dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_in1(s_in1), .s_in2(s_in2), .s_opcode(s_opcode),
        .m_valid(m_valid), .m_ready(m_ready), .m_in1(m_in1), .m_in2(m_in2),
        .m_opcode(m_opcode), .m_illegal(m_illegal), .m_shovf(m_shovf),
        .issue_cnt(issue_cnt), .illegal_cnt(illegal_cnt), .cnt_clr(cnt_clr)
    );

    alu_issue #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready4),
        .s_in1(s_in1), .s_in2(s_in2), .s_opcode(s_opcode),
        .m_valid(m_valid4), .m_ready(m_ready), .m_in1(m_in14), .m_in2(m_in24),
        .m_opcode(m_opcode4), .m_illegal(m_illegal4), .m_shovf(m_shovf4),
        .issue_cnt(issue_cnt4), .illegal_cnt(illegal_cnt4), .cnt_clr(cnt_clr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } op_t;

    op_t q[$];
    bit  mrdy = 1'b0;
    int  mi = 0, mil = 0, acc_n = 0;
    bit  m_acc, m_ret;
    op_t m_hd;

    function automatic bit f_ill(input op_t o);
        return (o.op == 3'd2) || (o.op == 3'd3);
    endfunction

    function automatic bit f_shovf(input op_t o);
        return (o.op == 3'd7) && (o.b > 32'd31);
    endfunction

    function automatic int f_cap(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            mrdy = 1'b0;
            mi   = 0;
            mil  = 0;
        end else begin
            m_acc = s_valid && mrdy;
            m_ret = (q.size() > 0) && m_ready;
            if (m_ret) begin
                m_hd = q.pop_front();
                mi++;
                if (f_ill(m_hd)) mil++;
            end
            if (cnt_clr) begin
                mi  = 0;
                mil = 0;
            end
            if (m_acc) begin
                q.push_back('{s_in1, s_in2, s_opcode});
                acc_n++;
            end
            mrdy = (q.size() < 2);
        end
    end

    task automatic cmp_port(input string t, input logic sr, input logic mv,
                            input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input logic il, input logic sh,
                            input logic [31:0] ic, input logic [31:0] lc, input int mx);
        op_t e;
        bit  ev;
        ev = (q.size() > 0);
        e  = ev ? q[0] : '0;
        chk({t, "s_ready"}, sr, mrdy);
        chk({t, "m_valid"}, mv, ev);
        chk({t, "m_in1"}, a, e.a);
        chk({t, "m_in2"}, b, e.b);
        chk({t, "m_opcode"}, op, e.op);
        chk({t, "m_illegal"}, il, ev && f_ill(e));
        chk({t, "m_shovf"}, sh, ev && f_shovf(e));
        chk({t, "issue_cnt"}, ic, f_cap(mi, mx));
        chk({t, "illegal_cnt"}, lc, f_cap(mil, mx));
    endtask

    always @(negedge clk) begin
        cmp_port("w16.", s_ready, m_valid, m_in1, m_in2, m_opcode, m_illegal, m_shovf,
                 {16'd0, issue_cnt}, {16'd0, illegal_cnt}, 65535);
        cmp_port("w4.", s_ready4, m_valid4, m_in14, m_in24, m_opcode4, m_illegal4, m_shovf4,
                 {28'd0, issue_cnt4}, {28'd0, illegal_cnt4}, 15);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        s_valid  = v;
        s_in1    = a;
        s_in2    = b;
        s_opcode = op;
    endtask

    initial begin
        int cyc;
        int tgt;
        #3;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_issue_cnt", issue_cnt, 16'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("s_ready_before_edge", s_ready, 1'b0);
        step();
        @(negedge clk);
        chk("s_ready_after_edge", s_ready, 1'b1);

        // single op, 1-cycle latency
        m_ready = 1'b1;
        drive(1'b1, 32'd5, 32'd3, 3'b000);
        step();
        drive(1'b0, 32'd0, 32'd0, 3'b000);
        @(negedge clk);
        chk("single_m_valid", m_valid, 1'b1);
        chk("single_m_in1", m_in1, 32'd5);
        chk("single_m_in2", m_in2, 32'd3);
        chk("single_m_opcode", m_opcode, 3'b000);
        step();
        @(negedge clk);
        chk("single_done_valid", m_valid, 1'b0);
        chk("single_issue_cnt", issue_cnt, 16'd1);

        // three back-to-back ops against a stalled ALU
        m_ready = 1'b0;
        drive(1'b1, 32'h11, 32'h1, 3'b001);
        step();
        drive(1'b1, 32'h22, 32'h2, 3'b001);
        step();
        drive(1'b1, 32'h33, 32'h3, 3'b001);
        @(negedge clk);
        chk("full_s_ready", s_ready, 1'b0);
        chk("full_head", m_in1, 32'h11);
        step();
        @(negedge clk);
        chk("stall_s_ready", s_ready, 1'b0);
        chk("stall_head", m_in1, 32'h11);
        m_ready = 1'b1;
        step();
        @(negedge clk);
        chk("drain_b_valid", m_valid, 1'b1);
        chk("drain_b", m_in1, 32'h22);
        chk("drain_s_ready", s_ready, 1'b1);
        step();
        drive(1'b0, 32'd0, 32'd0, 3'b000);
        @(negedge clk);
        chk("drain_c_valid", m_valid, 1'b1);
        chk("drain_c", m_in1, 32'h33);
        step();
        @(negedge clk);
        chk("drain_empty", m_valid, 1'b0);
        chk("drain_issue_cnt", issue_cnt, 16'd4);

        // illegal opcode then shift overflow
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        drive(1'b1, 32'd7, 32'd1, 3'b011);
        step();
        drive(1'b1, 32'd9, 32'd40, 3'b111);
        @(negedge clk);
        chk("ill_flag", m_illegal, 1'b1);
        chk("ill_opcode_fwd", m_opcode, 3'b011);
        chk("ill_shovf", m_shovf, 1'b0);
        step();
        drive(1'b0, 32'd0, 32'd0, 3'b000);
        @(negedge clk);
        chk("shovf_flag", m_shovf, 1'b1);
        chk("shovf_ill", m_illegal, 1'b0);
        step();
        @(negedge clk);
        chk("flags_issue_cnt", issue_cnt, 16'd2);
        chk("flags_illegal_cnt", illegal_cnt, 16'd1);

        // saturation on the 4-bit instance and clear priority
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int i = 0; i < 21; i++) begin
            drive(1'b1, 32'(i), 32'd0, 3'b000);
            step();
        end
        drive(1'b0, 32'd0, 32'd0, 3'b000);
        @(negedge clk);
        chk("sat_issue_cnt16", issue_cnt, 16'd20);
        chk("sat_issue_cnt4", issue_cnt4, 4'd15);
        chk("sat_pending", m_valid, 1'b1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_issue_cnt16", issue_cnt, 16'd0);
        chk("clr_issue_cnt4", issue_cnt4, 4'd0);
        chk("clr_retired", m_valid, 1'b0);

        // random traffic, checked by the per-cycle model compare
        tgt = acc_n + 10000;
        cyc = 0;
        while (acc_n < tgt && cyc < 60000) begin
            s_valid  = 1'($urandom_range(0, 1));
            m_ready  = 1'($urandom_range(0, 1));
            s_in1    = $urandom;
            s_in2    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
            s_opcode = 3'($urandom_range(0, 7));
            cnt_clr  = ($urandom_range(0, 63) == 0);
            step();
            cyc++;
        end
        chk("rand_ops_done", acc_n >= tgt, 1'b1);
        drive(1'b0, 32'd0, 32'd0, 3'b000);
        cnt_clr = 1'b0;
        m_ready = 1'b0;

        // async reset while full
        drive(1'b1, 32'hA1, 32'd1, 3'b000);
        step();
        drive(1'b1, 32'hA2, 32'd2, 3'b000);
        step();
        drive(1'b0, 32'd0, 32'd0, 3'b000);
        step();
        @(negedge clk);
        chk("pre_rst_valid", m_valid, 1'b1);
        chk("pre_rst_s_ready", s_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", m_valid, 1'b0);
        chk("mid_rst_s_ready", s_ready, 1'b0);
        chk("mid_rst_in1", m_in1, 32'd0);
        chk("mid_rst_issue_cnt", issue_cnt, 16'd0);
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready0", s_ready, 1'b0);
        repeat (3) step();
        @(negedge clk);
        chk("post_rst_no_stale", m_valid, 1'b0);
        chk("post_rst_issue_cnt", issue_cnt, 16'd0);
        chk("post_rst_s_ready1", s_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port s_valid  input  1  upstream operation valid.
REQ-005 SHALL have port s_ready  output  1  stage can accept an operation.
REQ-006 SHALL have ports s_in1, s_in2  input  32  operands; s_opcode  input  3  ALU opcode.
REQ-007 SHALL have port m_valid  output  1  operation presented to the ALU is valid.
REQ-008 SHALL have port m_ready  input  1  ALU side consumes the presented operation.
REQ-009 SHALL have ports m_in1, m_in2  output  32 and m_opcode  output  3, which drive the ALU in1/in2/opcode directly.
REQ-010 SHALL have port m_illegal  output  1  presented opcode is 3'b010 or 3'b011.
REQ-011 SHALL have port m_shovf  output  1  presented opcode is 3'b111 and m_in2 > 31.
REQ-012 SHALL have ports issue_cnt, illegal_cnt  output  CNT_W  statistics counters.
REQ-013 SHALL have port cnt_clr  input  1  synchronous clear of both counters.

Function
REQ-014 SHALL be a 2-entry in-order buffer (main + skid register) with occupancy states EMPTY, ONE, TWO.
REQ-015 SHALL accept an operation when s_valid && s_ready at a rising edge; SHALL present it when m_valid=1 and retire it when m_valid && m_ready.
REQ-016 SHALL drive s_ready from a register: 1 in EMPTY and ONE, 0 in TWO; no combinational path from m_ready to s_ready.
REQ-017 Transitions: EMPTY+accept->ONE; ONE+accept+no retire->TWO; ONE+retire+no accept->EMPTY; ONE+accept+retire->ONE; TWO+retire->ONE; all other cases hold state.
REQ-018 m_valid SHALL be 1 exactly in ONE and TWO; m_* fields SHALL come from the main register; when retiring from TWO, the skid entry SHALL move to main on the same edge.
REQ-019 Latency SHALL be 1 cycle: an operation accepted at edge N is presented from edge N onward (visible in cycle N+1) when the buffer was EMPTY.
REQ-020 Sustained throughput SHALL be 1 operation/cycle while m_ready=1; no bubbles on back-to-back traffic.
REQ-021 Order SHALL be preserved; no operation dropped or duplicated under any s_valid/m_ready pattern.
REQ-022 m_in1, m_in2, m_opcode SHALL hold stable while m_valid && !m_ready.
REQ-023 m_illegal and m_shovf SHALL be computed at accept time and stored with the entry; illegal opcodes SHALL still be forwarded unchanged.
REQ-024 issue_cnt SHALL increment by 1 per retire; illegal_cnt SHALL increment by 1 per retire with m_illegal=1.
REQ-025 Counters SHALL saturate at 2^CNT_W-1, not wrap.
REQ-026 cnt_clr=1 SHALL zero both counters at the edge, taking priority over a simultaneous increment (that event is not counted).
REQ-027 When m_valid=0, m_in1, m_in2, m_opcode, m_illegal, m_shovf SHALL be 0.

Reset
REQ-028 rst_n=0 SHALL immediately force state EMPTY, s_ready=0, m_valid=0, all m_* fields 0, both counters 0, regardless of clk.
REQ-029 s_ready SHALL rise to 1 at the first rising edge after rst_n deasserts; operations in flight at reset SHALL be discarded, not retired or counted.

Verification
REQ-030 Reset then single op s_in1=5, s_in2=3, opcode=000, m_ready=1 -> m_valid one cycle, m_in1=5, m_in2=3, m_opcode=000, issue_cnt=1.
REQ-031 Push 3 ops back-to-back with m_ready=0 -> first two accepted, s_ready=0 after the second, third held; release m_ready -> all three retired in order, no gaps.
REQ-032 Op with opcode=011 then opcode=111 with s_in2=40 -> first retires with m_illegal=1, second with m_shovf=1, m_illegal=0; illegal_cnt=1, issue_cnt=2.
REQ-033 CNT_W=4, 20 retires -> issue_cnt=15; cnt_clr asserted on a retire cycle -> issue_cnt=0 next cycle.
REQ-034 Random s_valid/m_ready (50% each), 10k ops, scoreboard -> output sequence equals input sequence, fields stable while stalled.
REQ-035 rst_n pulsed low mid-cycle while in TWO -> m_valid=0, s_ready=0 immediately; no stale operation appears after reset.
